// File: rtl/interrupt_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_sequencer
// Purpose  : 8259A-style priority resolver and INTA sequencer. It latches IR
//            requests into IRR, applies the mask and resolves the best request
//            against ISR under fully nested, optionally rotating, priority.
//            It drives INT, runs the two-pulse INTA handshake that delivers
//            {T7_T3, id}, and services automatic, non-specific and specific
//            EOI.
// Ports    : CLK, RESET (sync, active high)
//            IR[7:0], IMR[7:0], LTIM, AEOI, T7_T3[4:0]   - requests / config
//            INTA, EOI_CMD, EOI_SPECIFIC, EOI_LEVEL[2:0], ROTATE_EN
//            INT, VECTOR_OUT[7:0], VECTOR_VALID          - CPU side
//            IRR_OUT[7:0], ISR_OUT[7:0]                  - register read-back
// Revision : 1.0 - initial release
// ============================================================================
module interrupt_sequencer #(
  parameter int         NUM_IR   = 8,
  parameter logic [2:0] LP_RESET = 3'd7
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_IR-1:0] IR,
  input  logic [NUM_IR-1:0] IMR,
  input  logic              LTIM,
  input  logic              AEOI,
  input  logic [4:0]        T7_T3,
  input  logic              INTA,
  input  logic              EOI_CMD,
  input  logic              EOI_SPECIFIC,
  input  logic [2:0]        EOI_LEVEL,
  input  logic              ROTATE_EN,
  output logic              INT,
  output logic [7:0]        VECTOR_OUT,
  output logic              VECTOR_VALID,
  output logic [NUM_IR-1:0] IRR_OUT,
  output logic [NUM_IR-1:0] ISR_OUT
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } state_t;

  state_t            state, state_n;
  logic [NUM_IR-1:0] irr, irr_n;
  logic [NUM_IR-1:0] isr, isr_n;
  logic [NUM_IR-1:0] ir_prev;
  logic [2:0]        lp, lp_n;
  logic [2:0]        ack_id, ack_id_n;
  logic              spurious, spur_n;
  logic              int_n;
  logic [7:0]        vec_n;
  logic              vv_n;

  // Priority resolution results
  logic              cand_found, isr_found, winner_valid;
  logic [2:0]        cand_pos, isr_pos;
  logic [2:0]        cand_id, isr_id;
  logic [NUM_IR-1:0] pending;
  logic              eoi_rotated;

  assign pending = irr & ~IMR;
  assign IRR_OUT = irr;
  assign ISR_OUT = isr;

  // Walk from lowest priority (position 7 = LP) to highest (position 0 =
  // LP+1) so the last hit is the highest-priority set bit. Position is the
  // priority rank; smaller means more urgent.
  always_comb begin
    logic [2:0] lvl;
    lvl        = '0;
    cand_found = 1'b0;
    cand_pos   = '0;
    cand_id    = '0;
    isr_found  = 1'b0;
    isr_pos    = '0;
    isr_id     = '0;
    for (int k = NUM_IR - 1; k >= 0; k--) begin
      lvl = lp + 3'(k) + 3'd1;
      if (pending[lvl]) begin
        cand_found = 1'b1;
        cand_pos   = 3'(k);
        cand_id    = lvl;
      end
      if (isr[lvl]) begin
        isr_found = 1'b1;
        isr_pos   = 3'(k);
        isr_id    = lvl;
      end
    end
    winner_valid = cand_found && (!isr_found || (cand_pos < isr_pos));
  end

  // Next-state and output logic
  always_comb begin
    state_n     = state;
    int_n       = INT;
    isr_n       = isr;
    lp_n        = lp;
    ack_id_n    = ack_id;
    spur_n      = spurious;
    vec_n       = VECTOR_OUT;
    vv_n        = 1'b0;
    eoi_rotated = 1'b0;

    if (LTIM) begin
      irr_n = IR;
    end else begin
      irr_n = irr | (IR & ~ir_prev);
    end

    // EOI selection is made on the pre-edge ISR; the INTA set below is
    // applied afterwards so it wins on a shared bit.
    if (EOI_CMD) begin
      if (EOI_SPECIFIC) begin
        isr_n[EOI_LEVEL] = 1'b0;
        if (ROTATE_EN) begin
          lp_n        = EOI_LEVEL;
          eoi_rotated = 1'b1;
        end
      end else if (isr_found) begin
        isr_n[isr_id] = 1'b0;
        if (ROTATE_EN) begin
          lp_n        = isr_id;
          eoi_rotated = 1'b1;
        end
      end
    end

    case (state)
      S_IDLE: begin
        int_n = winner_valid;
        if (INTA && INT) begin
          int_n   = 1'b0;
          state_n = S_ACK;
          if (winner_valid) begin
            ack_id_n       = cand_id;
            spur_n         = 1'b0;
            isr_n[cand_id] = 1'b1;
            if (!LTIM) begin
              irr_n[cand_id] = 1'b0;
            end
          end else begin
            // Request vanished before the first acknowledge.
            ack_id_n = 3'd7;
            spur_n   = 1'b1;
          end
        end
      end
      S_ACK: begin
        int_n = 1'b0;
        if (INTA) begin
          vv_n    = 1'b1;
          vec_n   = {T7_T3, ack_id};
          state_n = S_IDLE;
          if (AEOI && !spurious) begin
            isr_n[ack_id] = 1'b0;
            if (ROTATE_EN && !eoi_rotated) begin
              lp_n = ack_id;
            end
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= S_IDLE;
      irr          <= '0;
      isr          <= '0;
      ir_prev      <= '0;
      lp           <= LP_RESET;
      ack_id       <= '0;
      spurious     <= 1'b0;
      INT          <= 1'b0;
      VECTOR_OUT   <= 8'h00;
      VECTOR_VALID <= 1'b0;
    end else begin
      state        <= state_n;
      irr          <= irr_n;
      isr          <= isr_n;
      ir_prev      <= IR;
      lp           <= lp_n;
      ack_id       <= ack_id_n;
      spurious     <= spur_n;
      INT          <= int_n;
      VECTOR_OUT   <= vec_n;
      VECTOR_VALID <= vv_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_interrupt_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_interrupt_sequencer
// Purpose  : Directed self-checking bench for interrupt_sequencer. A priority
//            model using rank arithmetic tracks IRR/ISR/LP and the acknowledge
//            phase; outputs are compared against it on every falling edge.
//            Hand-computed literals along the stimulus pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_interrupt_sequencer;

  logic       CLK, RESET;
  logic [7:0] IR, IMR;
  logic       LTIM, AEOI, INTA, EOI_CMD, EOI_SPECIFIC, ROTATE_EN;
  logic [4:0] T7_T3;
  logic [2:0] EOI_LEVEL;
  logic       INT, VECTOR_VALID;
  logic [7:0] VECTOR_OUT, IRR_OUT, ISR_OUT;

  int checks = 0;
  int errors = 0;

  interrupt_sequencer #(.NUM_IR(8), .LP_RESET(3'd7)) dut (
    .CLK(CLK), .RESET(RESET), .IR(IR), .IMR(IMR), .LTIM(LTIM), .AEOI(AEOI),
    .T7_T3(T7_T3), .INTA(INTA), .EOI_CMD(EOI_CMD), .EOI_SPECIFIC(EOI_SPECIFIC),
    .EOI_LEVEL(EOI_LEVEL), .ROTATE_EN(ROTATE_EN), .INT(INT),
    .VECTOR_OUT(VECTOR_OUT), .VECTOR_VALID(VECTOR_VALID),
    .IRR_OUT(IRR_OUT), .ISR_OUT(ISR_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Rank 0 is the most urgent level, i.e. LP+1; rank 7 is LP itself.
  function automatic int rank(input int lvl, input int lpv);
    return (lvl - lpv + 7) % 8;
  endfunction

  function automatic int top_of(input logic [7:0] v, input int lpv);
    int best = -1;
    for (int i = 0; i < 8; i++)
      if (v[i] && (best < 0 || rank(i, lpv) < rank(best, lpv))) best = i;
    return best;
  endfunction

  logic [7:0] m_irr, m_isr, m_prev, m_vec;
  int         m_lp, m_ack;
  bit         m_in_ack, m_spur, m_int, m_vv, started = 0;

  always @(posedge CLK) begin
    if (RESET) begin
      m_irr = 0; m_isr = 0; m_prev = 0; m_lp = 7; m_ack = 0;
      m_in_ack = 0; m_spur = 0; m_int = 0; m_vv = 0; m_vec = 0;
      started = 1;
    end else if (started) begin
      int cand, itop, lvl;
      bit wv, eoi_rot;
      logic [7:0] n_irr, n_isr;
      cand = top_of(m_irr & ~IMR, m_lp);
      itop = top_of(m_isr, m_lp);
      wv   = (cand >= 0) && (itop < 0 || rank(cand, m_lp) < rank(itop, m_lp));
      n_irr = LTIM ? IR : (m_irr | (IR & ~m_prev));
      n_isr = m_isr;
      eoi_rot = 0;
      if (EOI_CMD) begin
        lvl = EOI_SPECIFIC ? int'(EOI_LEVEL) : itop;
        if (lvl >= 0) begin
          n_isr[lvl] = 1'b0;
          if (ROTATE_EN) begin m_lp = lvl; eoi_rot = 1; end
        end
      end
      m_vv = 0;
      if (!m_in_ack) begin
        if (INTA && m_int) begin
          m_int = 0;
          m_in_ack = 1;
          if (wv) begin
            m_ack = cand; m_spur = 0; n_isr[cand] = 1'b1;
            if (!LTIM) n_irr[cand] = 1'b0;
          end else begin
            m_ack = 7; m_spur = 1;
          end
        end else begin
          m_int = wv;
        end
      end else begin
        m_int = 0;
        if (INTA) begin
          m_vv = 1;
          m_vec = {T7_T3, 3'(m_ack)};
          m_in_ack = 0;
          if (AEOI && !m_spur) begin
            n_isr[m_ack] = 1'b0;
            if (ROTATE_EN && !eoi_rot) m_lp = m_ack;
          end
        end
      end
      m_irr = n_irr; m_isr = n_isr; m_prev = IR;
    end
  end

  always @(negedge CLK) begin
    if (started) begin
      chk("int",   {7'd0, INT}, {7'd0, m_int});
      chk("valid", {7'd0, VECTOR_VALID}, {7'd0, m_vv});
      chk("irr",   IRR_OUT, m_irr);
      chk("isr",   ISR_OUT, m_isr);
      if (m_vv) chk("vector", VECTOR_OUT, m_vec);
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] vec;
  logic       vv;

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic ack_seq(output logic [7:0] v, output logic valid);
    INTA = 1; step(1); INTA = 0; step(1); INTA = 1; step(1);
    v = VECTOR_OUT; valid = VECTOR_VALID; INTA = 0;
  endtask

  task automatic eoi(input logic spec, input logic [2:0] lvl);
    EOI_SPECIFIC = spec; EOI_LEVEL = lvl; EOI_CMD = 1; step(1);
    EOI_CMD = 0; EOI_SPECIFIC = 0; EOI_LEVEL = 0;
  endtask

  task automatic pulse_ir(input logic [7:0] v);
    IR = v; step(1); IR = 0; step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    IR = 0; IMR = 0; LTIM = 0; AEOI = 0; INTA = 0; EOI_CMD = 0;
    EOI_SPECIFIC = 0; EOI_LEVEL = 0; ROTATE_EN = 0; T7_T3 = 5'b01000;
    RESET = 1;
    step(2);
    RESET = 0;
    chk("rst_int", {7'd0, INT}, 8'h00);
    chk("rst_valid", {7'd0, VECTOR_VALID}, 8'h00);
    chk("rst_vec", VECTOR_OUT, 8'h00);
    chk("rst_irr", IRR_OUT, 8'h00);
    chk("rst_isr", ISR_OUT, 8'h00);

    // Basic request on IR3
    IR = 8'h08; step(1);
    chk("t1_irr", IRR_OUT, 8'h08);
    chk("t1_int_early", {7'd0, INT}, 8'h00);
    step(1);
    chk("t1_int", {7'd0, INT}, 8'h01);
    ack_seq(vec, vv);
    IR = 0;
    chk("t1_vv", {7'd0, vv}, 8'h01);
    chk("t1_vec", vec, 8'h43);
    chk("t1_isr", ISR_OUT, 8'h08);
    chk("t1_irr2", IRR_OUT, 8'h00);

    // Nesting: IR5 is blocked by IR3 in service, IR1 preempts
    IR = 8'h20; step(1); IR = 0; step(3);
    chk("nest_int5", {7'd0, INT}, 8'h00);
    chk("nest_irr5", IRR_OUT, 8'h20);
    pulse_ir(8'h02);
    chk("nest_int1", {7'd0, INT}, 8'h01);
    ack_seq(vec, vv);
    chk("nest_vec1", vec, 8'h41);
    chk("nest_isr", ISR_OUT, 8'h0A);
    eoi(0, 0);
    chk("nest_eoi", ISR_OUT, 8'h08);
    eoi(0, 0);
    chk("nest_eoi2", ISR_OUT, 8'h00);
    step(1);
    chk("nest_int5b", {7'd0, INT}, 8'h01);
    ack_seq(vec, vv);
    chk("nest_vec5", vec, 8'h45);
    eoi(0, 0);
    chk("nest_clr", ISR_OUT, 8'h00);

    // Rotation with AEOI
    ROTATE_EN = 1; AEOI = 1;
    pulse_ir(8'h04);
    chk("rot_int2", {7'd0, INT}, 8'h01);
    ack_seq(vec, vv);
    chk("rot_vec2", vec, 8'h42);
    chk("rot_aeoi", ISR_OUT, 8'h00);
    pulse_ir(8'h11);
    chk("rot_int", {7'd0, INT}, 8'h01);
    ack_seq(vec, vv);
    chk("rot_vec4", vec, 8'h44);
    chk("rot_irr", IRR_OUT, 8'h01);
    step(1);
    chk("rot_int0", {7'd0, INT}, 8'h01);
    ack_seq(vec, vv);
    chk("rot_vec0", vec, 8'h40);
    chk("rot_isr", ISR_OUT, 8'h00);
    ROTATE_EN = 0; AEOI = 0;
    RESET = 1; step(1); RESET = 0;

    // Level mode, masking and spurious acknowledge
    LTIM = 1; IMR = 8'h01; IR = 8'h01; step(3);
    chk("lvl_masked", {7'd0, INT}, 8'h00);
    chk("lvl_irr", IRR_OUT, 8'h01);
    IMR = 8'h00; step(2);
    chk("lvl_int", {7'd0, INT}, 8'h01);
    IR = 0; step(1);
    chk("spur_int", {7'd0, INT}, 8'h01);
    chk("spur_irr", IRR_OUT, 8'h00);
    ack_seq(vec, vv);
    chk("spur_vv", {7'd0, vv}, 8'h01);
    chk("spur_vec", vec, 8'h47);
    chk("spur_isr", ISR_OUT, 8'h00);
    LTIM = 0;

    // Specific EOI and INTA-set-wins
    pulse_ir(8'h20);
    ack_seq(vec, vv);
    chk("spec_vec5", vec, 8'h45);
    pulse_ir(8'h10);
    chk("spec_int4", {7'd0, INT}, 8'h01);
    ack_seq(vec, vv);
    chk("spec_vec4", vec, 8'h44);
    chk("spec_isr", ISR_OUT, 8'h30);
    eoi(1, 3'd5);
    chk("spec_eoi5", ISR_OUT, 8'h10);
    eoi(1, 3'd4);
    chk("spec_eoi4", ISR_OUT, 8'h00);
    pulse_ir(8'h20);
    chk("win_int", {7'd0, INT}, 8'h01);
    INTA = 1; EOI_CMD = 1; EOI_SPECIFIC = 1; EOI_LEVEL = 3'd5; step(1);
    INTA = 0; EOI_CMD = 0; EOI_SPECIFIC = 0; EOI_LEVEL = 0;
    chk("win_isr", ISR_OUT, 8'h20);
    step(1); INTA = 1; step(1); INTA = 0;
    chk("win_vv", {7'd0, VECTOR_VALID}, 8'h01);
    chk("win_vec", VECTOR_OUT, 8'h45);
    eoi(0, 0);
    chk("win_clr", ISR_OUT, 8'h00);

    // Reset in the middle of an acknowledge
    pulse_ir(8'h08);
    chk("mid_int", {7'd0, INT}, 8'h01);
    INTA = 1; step(1); INTA = 0;
    chk("mid_isr", ISR_OUT, 8'h08);
    RESET = 1; step(1); RESET = 0;
    chk("mid_rst_isr", ISR_OUT, 8'h00);
    chk("mid_rst_int", {7'd0, INT}, 8'h00);
    INTA = 1; step(1); INTA = 0;
    chk("mid_no_vv", {7'd0, VECTOR_VALID}, 8'h00);
    step(1);
    chk("mid_no_vv2", {7'd0, VECTOR_VALID}, 8'h00);
    chk("mid_int2", {7'd0, INT}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
